// File: rtl/ddr_stream_router.sv
// Per-burst DDR read-data router: address handshakes queue {sink, size} routes, returning beats follow the head route.
// Optional sticky error flags are compiled in with DDR_ROUTE_ERR_EN.
module ddr_stream_router #(
    parameter int unsigned DDR_NUM     = 2,
    parameter int unsigned SINK_NUM    = 4,
    parameter int unsigned DDR_W       = 512,
    parameter int unsigned DDR_ADDR_W  = 32,
    parameter int unsigned BURST_W     = 8,
    parameter int unsigned ROUTE_DEPTH = 8,
    parameter int unsigned SINK_W      = $clog2(SINK_NUM + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DDR_NUM-1:0][DDR_ADDR_W-1:0]   in_addr,
    input  logic [DDR_NUM-1:0][BURST_W-1:0]      in_size,
    input  logic [DDR_NUM-1:0][SINK_W-1:0]       in_sink,
    input  logic [DDR_NUM-1:0]                   in_addr_valid,
    output logic [DDR_NUM-1:0]                   in_addr_ready,
    output logic [DDR_NUM-1:0][DDR_ADDR_W-1:0]   ddr_addr,
    output logic [DDR_NUM-1:0][BURST_W-1:0]      ddr_size,
    output logic [DDR_NUM-1:0]                   ddr_addr_valid,
    input  logic [DDR_NUM-1:0]                   ddr_addr_ready,
    input  logic [DDR_NUM-1:0][DDR_W-1:0]        ddr_data,
    input  logic [DDR_NUM-1:0]                   ddr_valid,
    output logic [DDR_NUM-1:0]                   ddr_ready,
    output logic [DDR_NUM-1:0][DDR_W-1:0]        sink_data,
    output logic [DDR_NUM-1:0][SINK_NUM-1:0]     sink_valid,
    output logic [DDR_NUM-1:0]                   sink_last,
    input  logic [DDR_NUM-1:0][SINK_NUM-1:0]     sink_ready,
    output logic [DDR_NUM-1:0]                   port_busy,
    output logic [DDR_NUM-1:0]                   err_orphan,
    output logic [DDR_NUM-1:0]                   err_bad_sink
);

    localparam int unsigned PTR_W = (ROUTE_DEPTH > 1) ? $clog2(ROUTE_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(ROUTE_DEPTH + 1);

    for (genvar p = 0; p < DDR_NUM; p++) begin : g_port
        logic [SINK_W-1:0]   route_sink [ROUTE_DEPTH];
        logic [BURST_W-1:0]  route_size [ROUTE_DEPTH];
        logic [PTR_W-1:0]    wr_ptr;
        logic [PTR_W-1:0]    rd_ptr;
        logic [OCC_W-1:0]    occ;
        logic [BURST_W-1:0]  cnt;
        logic                full;
        logic                empty;
        logic                push;
        logic                pop;
        logic                beat;
        logic                last;
        logic                sink_ok;
        logic                sel_ready;
        logic [SINK_W-1:0]   head_sink;
        logic [BURST_W-1:0]  head_size;
        logic [SINK_NUM-1:0] head_hit;

        assign full  = (occ == OCC_W'(ROUTE_DEPTH));
        assign empty = (occ == '0);

        // Address channel passes straight through, gated only by route FIFO space
        assign ddr_addr[p]       = in_addr[p];
        assign ddr_size[p]       = in_size[p];
        assign ddr_addr_valid[p] = in_addr_valid[p] & ~full;
        assign in_addr_ready[p]  = ddr_addr_ready[p] & ~full;
        assign push              = ddr_addr_valid[p] & ddr_addr_ready[p];

        assign head_sink = route_sink[rd_ptr];
        assign head_size = route_size[rd_ptr];

        for (genvar s = 0; s < SINK_NUM; s++) begin : g_hit
            assign head_hit[s] = (head_sink == SINK_W'(s));
        end

        // Out-of-range sink ids match no head_hit bit and are drained
        assign sink_ok      = |head_hit;
        assign sel_ready    = |(head_hit & sink_ready[p]);
        assign ddr_ready[p] = ~empty & (sink_ok ? sel_ready : 1'b1);
        assign sink_valid[p] = {SINK_NUM{ddr_valid[p] & ~empty}} & head_hit;
        assign sink_data[p]  = ddr_data[p];

        assign last         = ~empty & (cnt == head_size);
        assign sink_last[p] = last;
        assign beat         = ddr_valid[p] & ddr_ready[p];
        assign pop          = beat & last;
        assign port_busy[p] = ~empty;

        always_ff @(posedge clk) begin
            if (push) begin
                route_sink[wr_ptr] <= in_sink[p];
                route_size[wr_ptr] <= in_size[p];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
                cnt    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   occ <= occ + OCC_W'(1);
                    2'b01:   occ <= occ - OCC_W'(1);
                    default: occ <= occ;
                endcase
                if (pop) begin
                    cnt <= '0;
                end else if (beat) begin
                    cnt <= cnt + BURST_W'(1);
                end
            end
        end

`ifdef DDR_ROUTE_ERR_EN
        logic orphan_q;
        logic bad_sink_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                orphan_q   <= 1'b0;
                bad_sink_q <= 1'b0;
            end else begin
                if (ddr_valid[p] & empty) begin
                    orphan_q <= 1'b1;
                end
                if (beat & ~sink_ok) begin
                    bad_sink_q <= 1'b1;
                end
            end
        end

        assign err_orphan[p]   = orphan_q;
        assign err_bad_sink[p] = bad_sink_q;
`else
        assign err_orphan[p]   = 1'b0;
        assign err_bad_sink[p] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ddr_stream_router.sv
// Bench for ddr_stream_router: directed scenarios plus randomized traffic against a queue-based route model.
module tb_ddr_stream_router;

    localparam int unsigned DDR_NUM     = 2;
    localparam int unsigned SINK_NUM    = 4;
    localparam int unsigned DDR_W       = 32;
    localparam int unsigned DDR_ADDR_W  = 32;
    localparam int unsigned BURST_W     = 4;
    localparam int unsigned ROUTE_DEPTH = 8;
    localparam int unsigned SINK_W      = 3;
`ifdef DDR_ROUTE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                               clk;
    logic                               rst;
    logic [DDR_NUM-1:0][DDR_ADDR_W-1:0] in_addr;
    logic [DDR_NUM-1:0][BURST_W-1:0]    in_size;
    logic [DDR_NUM-1:0][SINK_W-1:0]     in_sink;
    logic [DDR_NUM-1:0]                 in_addr_valid;
    logic [DDR_NUM-1:0]                 in_addr_ready;
    logic [DDR_NUM-1:0][DDR_ADDR_W-1:0] ddr_addr;
    logic [DDR_NUM-1:0][BURST_W-1:0]    ddr_size;
    logic [DDR_NUM-1:0]                 ddr_addr_valid;
    logic [DDR_NUM-1:0]                 ddr_addr_ready;
    logic [DDR_NUM-1:0][DDR_W-1:0]      ddr_data;
    logic [DDR_NUM-1:0]                 ddr_valid;
    logic [DDR_NUM-1:0]                 ddr_ready;
    logic [DDR_NUM-1:0][DDR_W-1:0]      sink_data;
    logic [DDR_NUM-1:0][SINK_NUM-1:0]   sink_valid;
    logic [DDR_NUM-1:0]                 sink_last;
    logic [DDR_NUM-1:0][SINK_NUM-1:0]   sink_ready;
    logic [DDR_NUM-1:0]                 port_busy;
    logic [DDR_NUM-1:0]                 err_orphan;
    logic [DDR_NUM-1:0]                 err_bad_sink;

    ddr_stream_router #(
        .DDR_NUM(DDR_NUM), .SINK_NUM(SINK_NUM), .DDR_W(DDR_W), .DDR_ADDR_W(DDR_ADDR_W),
        .BURST_W(BURST_W), .ROUTE_DEPTH(ROUTE_DEPTH), .SINK_W(SINK_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_addr(in_addr), .in_size(in_size), .in_sink(in_sink),
        .in_addr_valid(in_addr_valid), .in_addr_ready(in_addr_ready),
        .ddr_addr(ddr_addr), .ddr_size(ddr_size),
        .ddr_addr_valid(ddr_addr_valid), .ddr_addr_ready(ddr_addr_ready),
        .ddr_data(ddr_data), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_last(sink_last),
        .sink_ready(sink_ready), .port_busy(port_busy),
        .err_orphan(err_orphan), .err_bad_sink(err_bad_sink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: outstanding routes as queues, beats delivered so far in the head burst
    int q_sink [DDR_NUM][$];
    int q_size [DDR_NUM][$];
    int done   [DDR_NUM];
    bit m_orph [DDR_NUM];
    bit m_bad  [DDR_NUM];

    task automatic model_reset();
        for (int p = 0; p < DDR_NUM; p++) begin
            q_sink[p].delete();
            q_size[p].delete();
            done[p]   = 0;
            m_orph[p] = 1'b0;
            m_bad[p]  = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < DDR_NUM; p++) begin
                automatic bit full = (q_sink[p].size() == ROUTE_DEPTH);
                automatic bit emp  = (q_sink[p].size() == 0);
                automatic logic [SINK_NUM-1:0] ev = '0;
                automatic bit er = 1'b0;
                automatic bit el = 1'b0;
                automatic int h  = 0;
                if (!emp) begin
                    h = q_sink[p][0];
                    if (h < SINK_NUM) begin
                        ev[h] = ddr_valid[p];
                        er    = sink_ready[p][h];
                    end else begin
                        er = 1'b1;
                    end
                    el = (done[p] == q_size[p][0]);
                end
                check($sformatf("in_addr_ready[%0d]", p), 64'(in_addr_ready[p]), 64'(ddr_addr_ready[p] && !full));
                check($sformatf("ddr_addr_valid[%0d]", p), 64'(ddr_addr_valid[p]), 64'(in_addr_valid[p] && !full));
                check($sformatf("ddr_addr[%0d]", p), 64'(ddr_addr[p]), 64'(in_addr[p]));
                check($sformatf("ddr_size[%0d]", p), 64'(ddr_size[p]), 64'(in_size[p]));
                check($sformatf("ddr_ready[%0d]", p), 64'(ddr_ready[p]), 64'(er));
                check($sformatf("sink_valid[%0d]", p), 64'(sink_valid[p]), 64'(ev));
                check($sformatf("sink_last[%0d]", p), 64'(sink_last[p]), 64'(el));
                check($sformatf("sink_data[%0d]", p), 64'(sink_data[p]), 64'(ddr_data[p]));
                check($sformatf("port_busy[%0d]", p), 64'(port_busy[p]), 64'(!emp));
                check($sformatf("err_orphan[%0d]", p), 64'(err_orphan[p]), 64'(m_orph[p]));
                check($sformatf("err_bad_sink[%0d]", p), 64'(err_bad_sink[p]), 64'(m_bad[p]));
                // advance model to the state after the coming rising edge
                if (ERR_EN && ddr_valid[p] && emp) m_orph[p] = 1'b1;
                if (ddr_valid[p] && er) begin
                    if (ERR_EN && h >= SINK_NUM) m_bad[p] = 1'b1;
                    if (el) begin
                        void'(q_sink[p].pop_front());
                        void'(q_size[p].pop_front());
                        done[p] = 0;
                    end else begin
                        done[p]++;
                    end
                end
                if (in_addr_valid[p] && !full && ddr_addr_ready[p]) begin
                    q_sink[p].push_back(int'(in_sink[p]));
                    q_size[p].push_back(int'(in_size[p]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_addr        = '0;
        in_size        = '0;
        in_sink        = '0;
        in_addr_valid  = '0;
        ddr_addr_ready = '0;
        ddr_data       = '0;
        ddr_valid      = '0;
        sink_ready     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        step();
        step();
        check("rst_port_busy", 64'(port_busy), 64'(0));
        check("rst_sink_valid", 64'(sink_valid), 64'(0));
        check("rst_ddr_ready", 64'(ddr_ready), 64'(0));
        check("rst_sink_last", 64'(sink_last), 64'(0));
        check("rst_err_orphan", 64'(err_orphan), 64'(0));
        check("rst_err_bad_sink", 64'(err_bad_sink), 64'(0));
        rst = 1'b0;
    endtask

    task automatic push_route(input int p, input int sink, input int size);
        in_addr[p]        = $urandom;
        in_sink[p]        = SINK_W'(sink);
        in_size[p]        = BURST_W'(size);
        in_addr_valid[p]  = 1'b1;
        ddr_addr_ready[p] = 1'b1;
    endtask

    initial begin
        automatic int beats;
        automatic int last_at;
        automatic logic [SINK_NUM-1:0] exp_v [3] = '{4'b0010, 4'b1000, 4'b1000};
        automatic bit exp_l [3] = '{1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        idle_inputs();
        #1;
        do_reset();

        // single burst: port 0, sink 2, size 3
        push_route(0, 2, 3);
        step();
        in_addr_valid = '0;
        sink_ready    = '1;
        ddr_valid[0]  = 1'b1;
        beats   = 0;
        last_at = -1;
        for (int i = 0; i < 4; i++) begin
            ddr_data[0] = $urandom;
            @(negedge clk);
            if (sink_valid[0][2] && ddr_ready[0]) beats++;
            if (sink_last[0]) last_at = i;
            step();
        end
        ddr_valid[0] = 1'b0;
        @(negedge clk);
        check("t1_busy_after", 64'(port_busy[0]), 64'(0));
        check("t1_beats", 64'(beats), 64'(4));
        check("t1_last_at", 64'(last_at), 64'(3));

        // back-to-back bursts on port 0
        do_reset();
        push_route(0, 1, 0);
        step();
        push_route(0, 3, 1);
        step();
        in_addr_valid = '0;
        sink_ready    = '1;
        ddr_valid[0]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t2_valid_b%0d", i), 64'(sink_valid[0]), 64'(exp_v[i]));
            check($sformatf("t2_last_b%0d", i), 64'(sink_last[0]), 64'(exp_l[i]));
            check($sformatf("t2_ready_b%0d", i), 64'(ddr_ready[0]), 64'(1));
            step();
        end
        ddr_valid[0] = 1'b0;

        // fill route FIFO, then free one slot
        do_reset();
        push_route(0, 1, 0);
        for (int i = 0; i < ROUTE_DEPTH; i++) step();
        @(negedge clk);
        check("t3_full_ready", 64'(in_addr_ready[0]), 64'(0));
        step();
        sink_ready   = '1;
        ddr_valid[0] = 1'b1;
        step();
        ddr_valid[0] = 1'b0;
        @(negedge clk);
        check("t3_slot_ready", 64'(in_addr_ready[0]), 64'(1));
        step();
        in_addr_valid = '0;
        @(negedge clk);
        check("t3_refull_ready", 64'(in_addr_ready[0]), 64'(0));

        // stall mid-burst for 5 cycles
        do_reset();
        push_route(0, 0, 5);
        step();
        in_addr_valid = '0;
        sink_ready[0] = 4'b0001;
        ddr_valid[0]  = 1'b1;
        step();
        step();
        sink_ready[0] = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_ready", 64'(ddr_ready[0]), 64'(0));
            step();
        end
        sink_ready[0] = 4'b0001;
        beats   = 0;
        last_at = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ddr_ready[0]) beats++;
            if (sink_last[0]) last_at = i;
            step();
        end
        ddr_valid[0] = 1'b0;
        check("t4_resume_beats", 64'(beats), 64'(4));
        check("t4_resume_last", 64'(last_at), 64'(3));

        // both ports to sink 0, port 0 stalled
        do_reset();
        push_route(0, 0, 2);
        push_route(1, 0, 2);
        step();
        in_addr_valid = '0;
        sink_ready    = '0;
        sink_ready[1] = 4'b0001;
        ddr_valid     = '1;
        for (int i = 0; i < 3; i++) step();
        ddr_valid = '0;
        @(negedge clk);
        check("t5_p1_done", 64'(port_busy[1]), 64'(0));
        check("t5_p0_held", 64'(port_busy[0]), 64'(1));

        // orphan beat and out-of-range sink
        do_reset();
        ddr_valid[1] = 1'b1;
        step();
        ddr_valid[1] = 1'b0;
        push_route(0, 5, 1);
        step();
        in_addr_valid = '0;
        ddr_valid[0]  = 1'b1;
        @(negedge clk);
        check("t6_drain_ready", 64'(ddr_ready[0]), 64'(1));
        check("t6_drain_valid", 64'(sink_valid[0]), 64'(0));
        step();
        step();
        ddr_valid[0] = 1'b0;
        @(negedge clk);
        check("t6_orphan", 64'(err_orphan[1]), 64'(ERR_EN));
        check("t6_bad_sink", 64'(err_bad_sink[0]), 64'(ERR_EN));
        check("t6_drained", 64'(port_busy[0]), 64'(0));
        do_reset();

        // randomized traffic, with one asynchronous reset in the middle
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) do_reset();
            for (int p = 0; p < DDR_NUM; p++) begin
                in_addr[p]        = $urandom;
                in_sink[p]        = ($urandom_range(0, 15) == 0) ? SINK_W'($urandom_range(4, 7))
                                                                 : SINK_W'($urandom_range(0, 3));
                in_size[p]        = ($urandom_range(0, 15) == 0) ? BURST_W'(15)
                                                                 : BURST_W'($urandom_range(0, 3));
                in_addr_valid[p]  = ($urandom_range(0, 3) == 0);
                ddr_addr_ready[p] = ($urandom_range(0, 3) != 0);
                ddr_data[p]       = $urandom;
                ddr_valid[p]      = ($urandom_range(0, 3) != 0);
                sink_ready[p]     = SINK_NUM'($urandom) | SINK_NUM'($urandom);
            end
            step();
        end

        idle_inputs();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ddr_stream_router.md
# ddr_stream_router

Parametrised DDR read-data router sitting between the DDR address generators, the DDR read ports and the PE-side buffer loaders (index, data, parameter, accumulator/bias). It replaces the static per-phase ready mux with per-burst routing. Each address-channel handshake records the destination sink and burst length in a per-port route FIFO. Returning beats are then steered to that sink until the burst completes. This lets loaders for different buffers share a DDR port with multiple outstanding bursts.

## Interface
Parameters:
- DDR_NUM, 2, number of DDR read ports
- SINK_NUM, 4, number of buffer loaders per port
- DDR_W, 512, DDR data width
- DDR_ADDR_W, 32, DDR address width
- BURST_W, 8, burst size field width
- ROUTE_DEPTH, 8, route FIFO entries per port (power of 2)
- SINK_W, bw(SINK_NUM), sink id width

Ports (all arrays indexed [DDR_NUM-1:0], sink arrays [DDR_NUM-1:0][SINK_NUM-1:0]):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_addr  in  [DDR_NUM][DDR_ADDR_W]  address from generator
- in_size  in  [DDR_NUM][BURST_W]  burst beats minus 1
- in_sink  in  [DDR_NUM][SINK_W]  destination loader id
- in_addr_valid / in_addr_ready  in/out  [DDR_NUM]  generator handshake
- ddr_addr, ddr_size  out  as in_addr/in_size  to DDR
- ddr_addr_valid / ddr_addr_ready  out/in  [DDR_NUM]  DDR address handshake
- ddr_data  in  [DDR_NUM][DDR_W]; ddr_valid in, ddr_ready out  [DDR_NUM]  read data
- sink_data  out  [DDR_NUM][DDR_W]  fan-out of ddr_data
- sink_valid  out  [DDR_NUM][SINK_NUM]  one-hot per port
- sink_last  out  [DDR_NUM]  last beat of current burst
- sink_ready  in  [DDR_NUM][SINK_NUM]
- port_busy  out  [DDR_NUM]  route FIFO non-empty
- err_orphan, err_bad_sink  out  [DDR_NUM]  sticky error flags

## Operation
- Address path is combinational pass-through per port:
  - ddr_addr = in_addr; ddr_size = in_size.
  - ddr_addr_valid = in_addr_valid & !full.
  - in_addr_ready = ddr_addr_ready & !full.
- Push {in_sink, in_size} into the port's route FIFO when ddr_addr_valid & ddr_addr_ready.
- Head entry selects the sink h:
  - sink_valid[p][h] = ddr_valid[p] & !empty.
  - ddr_ready[p] = sink_ready[p][h] & !empty.
  - All other sink_valid are 0.
- Beat counter per port, width BURST_W, counts accepted beats (ddr_valid & ddr_ready).
  - sink_last = !empty & (cnt == head size).
  - On an accepted last beat: cnt <- 0, pop the head.
- Burst of size 0 is a single beat; size 2^BURST_W-1 is the maximum.
- Empty FIFO: ddr_ready = 0, no sink_valid, data held in DDR.
- Full FIFO: no push, even if a pop happens the same cycle.
- Simultaneous push and pop on a non-full FIFO: occupancy unchanged.
- Ports are fully independent; the same sink id on two ports drives two separate valid lines.
- Head sink id >= SINK_NUM: beats are drained (ddr_ready = 1, no sink_valid) and counted; the burst is popped normally.

## Timing
- Reset values: FIFO pointers, occupancy, beat counters and error flags all 0.
  - Consequently port_busy = 0, sink_valid = 0, ddr_ready = 0, sink_last = 0.
  - Address outputs follow the inputs.
- Async reset mid-burst discards all outstanding routes and the partial beat count. The DDR side must be reset together.
- Address to data: a FIFO push is registered. A beat is routable from the cycle after its address handshake; earlier beats stall.
- Data path has zero latency (combinational valid/ready/data). Throughput is one beat per cycle per port.
- port_busy deasserts in the cycle after the pop of the final entry.

## Configuration
- DDR_ROUTE_ERR_EN defined:
  - err_orphan[p] sets on a cycle with ddr_valid[p] & empty.
  - err_bad_sink[p] sets on a drained beat with an out-of-range sink.
  - Both flags are sticky until rst.
- Not defined: both flags tied to 0 and their logic removed. Routing and drain behaviour are identical either way.

## Test plan
- Single burst, port 0, sink 2, size 3; sink_ready held 1 -> 4 beats on sink_valid[0][2], sink_last on 4th, port_busy 0 one cycle later.
- Port 0 queues sink 1 size 0 then sink 3 size 1 back-to-back -> beat 1 to sink 1 with last, beats 2-3 to sink 3, last on beat 3, no gap cycle.
- Fill ROUTE_DEPTH=8 entries with no data -> in_addr_ready 0 on the 9th request. Complete one burst -> 9th accepted the next cycle.
- sink_ready deasserted for 5 cycles mid-burst -> ddr_ready 0, beat count frozen, resumes exactly at the held beat.
- Ports 0 and 1 both target sink 0 concurrently -> independent streams, no cross-stall.
- With DDR_ROUTE_ERR_EN: ddr_valid on an empty port 1 -> err_orphan[1]=1 and held. A sink id of 5 with SINK_NUM=4 -> beats drained, err_bad_sink=1. rst clears both flags.
